// File: rtl/branch_hazard_controller.sv
// ID-stage control-transfer and hazard sequencer: selects the next-PC source, stalls on operand hazards and squashes the wrong-path slot.
// Optional statistics counters (taken_cnt, stall_cnt) are built only when BRANCH_STATS_EN is defined.
module branch_hazard_controller #(
    parameter int STALL_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             rs_equal,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    output logic [1:0]       pc_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             id_kill
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;
    localparam logic [1:0] SEL_REG    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_REDIRECT
    } state_t;

    state_t             state_reg, state_next;
    logic [STALL_W-1:0] cnt_reg, cnt_next;

    logic is_rtype, is_j, is_jr, is_jalr, is_beq, is_bne, is_sw;
    logic is_branch, is_reg_jump, id_resolved, rt_source;
    logic rs_hit_ex, rt_hit_ex, hit_ex, rs_hit_mem, rt_hit_mem, hit_mem;
    logic taken;
    logic [1:0] taken_sel;
    logic [STALL_W-1:0] need;
    logic redirect, stall;

    // Opcode / funct decode
    assign is_rtype    = (id_opcode == OP_RTYPE);
    assign is_j        = (id_opcode == OP_J) || (id_opcode == OP_JAL);
    assign is_jr       = is_rtype && (id_funct == FN_JR);
    assign is_jalr     = is_rtype && (id_funct == FN_JALR);
    assign is_beq      = (id_opcode == OP_BEQ);
    assign is_bne      = (id_opcode == OP_BNE);
    assign is_sw       = (id_opcode == OP_SW);
    assign is_branch   = is_beq || is_bne;
    assign is_reg_jump = is_jr || is_jalr;
    assign id_resolved = is_branch || is_reg_jump;
    assign rt_source   = is_rtype || is_branch || is_sw;

    // Register $0 never creates a dependency
    assign rs_hit_ex  = (id_rs != 5'd0) && (id_rs == ex_rd);
    assign rt_hit_ex  = rt_source && (id_rt != 5'd0) && (id_rt == ex_rd);
    assign hit_ex     = rs_hit_ex || rt_hit_ex;
    assign rs_hit_mem = (id_rs != 5'd0) && (id_rs == mem_rd);
    assign rt_hit_mem = rt_source && (id_rt != 5'd0) && (id_rt == mem_rd);
    assign hit_mem    = rs_hit_mem || rt_hit_mem;

    assign taken = is_j || is_reg_jump || (is_beq && rs_equal) || (is_bne && !rs_equal);

    always_comb begin
        taken_sel = SEL_PC4;
        if (is_j)
            taken_sel = SEL_JUMP;
        else if (is_branch)
            taken_sel = SEL_BRANCH;
        else if (is_reg_jump)
            taken_sel = SEL_REG;
    end

    // Stall cycles needed before the ID instruction may proceed (maximum over all causes)
    always_comb begin
        need = '0;
        if (id_resolved) begin
            if (hit_ex && ex_mem_read)
                need = STALL_W'(2);
            else if (hit_ex && ex_reg_write)
                need = STALL_W'(1);
            if (hit_mem && mem_mem_read && need == '0)
                need = STALL_W'(1);
        end else if (hit_ex && ex_mem_read) begin
            need = STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pc_sel      = SEL_PC4;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        id_kill     = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (id_valid && need != '0) begin
                    stall    = 1'b1;
                    cnt_next = need - STALL_W'(1);
                    if (need > STALL_W'(1))
                        state_next = ST_HOLD;
                end else if (id_valid && taken) begin
                    redirect   = 1'b1;
                    pc_sel     = taken_sel;
                    state_next = ST_REDIRECT;
                end
            end
            ST_HOLD: begin
                stall = 1'b1;
                if (cnt_reg <= STALL_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - STALL_W'(1);
                end
            end
            ST_REDIRECT: begin
                id_kill     = 1'b1;
                idex_bubble = 1'b1;
                state_next  = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
        // Reset is asynchronous, so the outputs must reflect it without waiting for a clock
        if (!rst_n) begin
            pc_sel      = SEL_PC4;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            id_kill     = 1'b0;
            redirect    = 1'b0;
            stall       = 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_reg, stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (redirect && taken_cnt_reg != '1)
                taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
            if (stall && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign taken_cnt = taken_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed-vector bench for branch_hazard_controller; expected outputs are queued per cycle and checked by a separate monitor.
module tb_branch_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [5:0] id_funct = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       rs_equal = 1'b0;
    logic       ex_reg_write = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       mem_mem_read = 1'b0;
    logic [4:0] mem_rd = '0;
    logic [1:0] pc_sel;
    logic       pc_write, ifid_write, idex_bubble, id_kill;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt, stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Expected vector layout: {pc_sel, pc_write, ifid_write, idex_bubble, id_kill}
    localparam logic [5:0] E_RST   = 6'b00_0_0_1_0;
    localparam logic [5:0] E_STALL = 6'b00_0_0_1_0;
    localparam logic [5:0] E_NORM  = 6'b00_1_1_0_0;
    localparam logic [5:0] E_KILL  = 6'b00_1_1_1_1;
    localparam logic [5:0] E_JMP   = 6'b01_1_1_0_0;
    localparam logic [5:0] E_BR    = 6'b10_1_1_0_0;
    localparam logic [5:0] E_JR    = 6'b11_1_1_0_0;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000, FN_JALR = 6'b001001;

    typedef struct {
        logic [5:0] exp;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    branch_hazard_controller #(.STALL_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .rs_equal(rs_equal),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .pc_sel(pc_sel),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .id_kill(id_kill)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: inputs change just after the rising edge, expectation is queued
    task automatic cyc(input logic r, input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic eq,
                       input logic exw, input logic exl, input logic [4:0] exrd,
                       input logic meml, input logic [4:0] memrd,
                       input logic [5:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid = v; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt;
        rs_equal = eq; ex_reg_write = exw; ex_mem_read = exl; ex_rd = exrd;
        mem_mem_read = meml; mem_rd = memrd; rst_n = r;
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [5:0] exp, input string name);
        cyc(1, 0, OP_R, '0, 0, 0, 0, 0, 0, 0, 0, 0, exp, name);
    endtask

    // Monitor: outputs are combinational, so every queued cycle is sampled at the falling edge
    initial begin
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                act = {pc_sel, pc_write, ifid_write, idex_bubble, id_kill};
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got %b expected %b (pc_sel,pc_write,ifid_write,idex_bubble,id_kill)",
                             e.name, act, e.exp);
                end else begin
                    $display("ok   %s: %b", e.name, act);
                end
            end
        end
    end

    initial begin
        // reset held, then first free-running cycle
        cyc(0, 0, OP_R, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, "reset_held");
        idle(E_NORM, "idle_after_reset");
        // J: redirect, squash, resume (killed J is ignored)
        cyc(1, 1, OP_J, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_JMP, "j_redirect");
        cyc(1, 1, OP_J, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_KILL, "j_kill_slot");
        idle(E_NORM, "j_after_kill");
        // BEQ not taken / taken
        cyc(1, 1, OP_BEQ, '0, 3, 4, 0, 0, 0, 0, 0, 0, E_NORM, "beq_not_taken");
        cyc(1, 1, OP_BEQ, '0, 3, 4, 1, 0, 0, 0, 0, 0, E_BR, "beq_taken");
        idle(E_KILL, "beq_kill_slot");
        // BNE behind a load in EX: two stall cycles
        cyc(1, 1, OP_BNE, '0, 5, 0, 0, 1, 1, 5, 0, 0, E_STALL, "bne_load_stall1");
        cyc(1, 1, OP_BNE, '0, 5, 0, 0, 1, 1, 5, 0, 0, E_STALL, "bne_load_stall2");
        cyc(1, 1, OP_BNE, '0, 5, 0, 0, 0, 0, 0, 0, 0, E_BR, "bne_taken");
        idle(E_KILL, "bne_kill_slot");
        // load-use on ALU op, and register-zero / non-load exemptions
        cyc(1, 1, OP_R, FN_ADD, 7, 8, 0, 0, 1, 7, 0, 0, E_STALL, "add_load_use");
        cyc(1, 1, OP_R, FN_ADD, 7, 8, 0, 0, 0, 0, 0, 0, E_NORM, "add_resume");
        cyc(1, 1, OP_R, FN_ADD, 0, 8, 0, 0, 1, 0, 0, 0, E_NORM, "add_r0_no_stall");
        cyc(1, 1, OP_R, FN_ADD, 7, 8, 0, 1, 0, 7, 0, 0, E_NORM, "add_alu_ex_no_stall");
        // rt is a source for SW but not for LW
        cyc(1, 1, OP_SW, '0, 1, 12, 0, 0, 1, 12, 0, 0, E_STALL, "sw_rt_load_use");
        cyc(1, 1, OP_LW, '0, 1, 12, 0, 0, 1, 12, 0, 0, E_NORM, "lw_rt_not_source");
        // branch behind a load in MEM: one stall; ALU result in MEM: none
        cyc(1, 1, OP_BEQ, '0, 6, 0, 1, 0, 0, 0, 1, 6, E_STALL, "beq_mem_load_stall");
        cyc(1, 1, OP_BEQ, '0, 6, 0, 1, 0, 0, 0, 0, 0, E_BR, "beq_after_mem_stall");
        idle(E_KILL, "beq_mem_kill_slot");
        cyc(1, 1, OP_BEQ, '0, 6, 0, 0, 0, 0, 0, 0, 6, E_NORM, "beq_mem_alu_no_stall");
        // JR behind an ALU write in EX: one stall then rs redirect
        cyc(1, 1, OP_R, FN_JR, 9, 0, 0, 1, 0, 9, 0, 0, E_STALL, "jr_alu_stall");
        cyc(1, 1, OP_R, FN_JR, 9, 0, 0, 0, 0, 0, 0, 0, E_JR, "jr_taken");
        idle(E_KILL, "jr_kill_slot");
        // reset during REDIRECT
        cyc(1, 1, OP_JAL, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_JMP, "jal_redirect");
        cyc(0, 0, OP_R, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, "reset_in_redirect");
        idle(E_NORM, "run_after_redirect_reset");
        // reset during HOLD
        cyc(1, 1, OP_R, FN_JALR, 10, 0, 0, 1, 1, 10, 0, 0, E_STALL, "jalr_load_stall");
        cyc(0, 1, OP_R, FN_JALR, 10, 0, 0, 1, 1, 10, 0, 0, E_RST, "reset_in_hold");
        idle(E_NORM, "run_after_hold_reset");

`ifdef BRANCH_STATS_EN
        cyc(0, 0, OP_R, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, "stats_reset");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, OP_J, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_JMP, "stats_j");
            idle(E_KILL, "stats_j_kill");
        end
        cyc(1, 1, OP_BNE, '0, 5, 0, 1, 1, 1, 5, 0, 0, E_STALL, "stats_stall1");
        cyc(1, 1, OP_BNE, '0, 5, 0, 1, 1, 1, 5, 0, 0, E_STALL, "stats_stall2");
        cyc(1, 1, OP_BNE, '0, 5, 0, 1, 0, 0, 0, 0, 0, E_NORM, "stats_bne_not_taken");
        @(negedge clk);
        #1;
        checks++;
        if (taken_cnt !== 16'd3) begin
            failures++;
            $display("FAIL taken_cnt: got %0d expected 3", taken_cnt);
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            failures++;
            $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
        end
        force dut.taken_cnt_reg = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.taken_cnt_reg;
        cyc(1, 1, OP_J, '0, 0, 0, 0, 0, 0, 0, 0, 0, E_JMP, "stats_sat_j");
        idle(E_KILL, "stats_sat_kill");
        @(negedge clk);
        #1;
        checks++;
        if (taken_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL taken_cnt_saturate: got %h expected ffff", taken_cnt);
        end
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
